// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: widths, frame layout and FSM encodings.
package prog_loader_pkg;
    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 128;
    localparam int INSN_LEN = 32;

    localparam int HDR_BYTES       = 4;
    localparam int IMEM_UNIT_BYTES = 16;
    localparam int DMEM_UNIT_BYTES = 4;

    localparam logic [2:0] S_HDR_I = 3'd0;
    localparam logic [2:0] S_IMEM  = 3'd1;
    localparam logic [2:0] S_HDR_D = 3'd2;
    localparam logic [2:0] S_DMEM  = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/prog_loader_byte_asm.sv
// Byte assembler: shifts bytes in MSB-first and flags the last byte of a 16-byte
// imem line or a 4-byte dmem word.
module prog_byte_asm
    import prog_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic                i_imem,
    input  logic [7:0]          i_byte,
    output logic [DATA_LEN-1:0] o_next,
    output logic                o_last
);
    logic [DATA_LEN-9:0] r_data;
    logic [3:0]          r_cnt;
    logic                w_end;

    assign w_end  = i_imem ? (r_cnt == 4'(IMEM_UNIT_BYTES - 1))
                           : (r_cnt == 4'(DMEM_UNIT_BYTES - 1));
    assign o_next = {r_data, i_byte};
    assign o_last = i_en & w_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_en) begin
            r_data <= o_next[DATA_LEN-9:0];
            r_cnt  <= w_end ? 4'd0 : r_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader feeding imem lines and dmem words while holding
// the core in reset. Define PROG_LOADER_CHKSUM_EN to require a trailing checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_LINES_MAX = 512,
    parameter int DMEM_WORDS_MAX = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [DATA_LEN-1:0] prog_loaddata,
    output logic [ADDR_LEN-1:0] prog_loadaddr,
    output logic                prog_imem_we,
    output logic                prog_dmem_we,
    output logic                prog_loading,
    output logic                loaded,
    output logic                load_err
);
    localparam int IW = max_int($clog2(IMEM_LINES_MAX) + 1, $clog2(DMEM_WORDS_MAX) + 1);
`ifdef PROG_LOADER_CHKSUM_EN
    localparam logic [2:0] S_LAST = S_CHK;
`else
    localparam logic [2:0] S_LAST = S_DONE;
`endif

    logic [2:0]          r_state;
    logic                r_rdy;
    logic [1:0]          r_hcnt;
    logic [23:0]         r_hdr;
    logic [IW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [DATA_LEN-1:0] r_loaddata;
    logic [ADDR_LEN-1:0] r_loadaddr;
    logic                r_imem_we;
    logic                r_dmem_we;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]          r_sum;
`endif

    logic                w_acc;
    logic                w_payload;
    logic                w_asm_last;
    logic [DATA_LEN-1:0] w_asm_next;
    logic [31:0]         w_hval;
    logic [2:0]          w_hdr_next;
    logic                w_sec_end;

    // Ready is withheld in the strobe cycle so index/state update never races a new byte.
    assign rx_ready  = r_rdy & ~r_imem_we & ~r_dmem_we &
                       (r_state == S_HDR_I || r_state == S_IMEM || r_state == S_HDR_D ||
                        r_state == S_DMEM  || r_state == S_CHK);
    assign w_acc     = rx_valid & rx_ready;
    assign w_payload = (r_state == S_IMEM) || (r_state == S_DMEM);
    assign w_hval    = {rx_data, r_hdr};
    assign w_sec_end = (r_idx + IW'(1)) == r_cnt;

    prog_byte_asm u_asm (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_acc & w_payload),
        .i_imem (r_state == S_IMEM),
        .i_byte (rx_data),
        .o_next (w_asm_next),
        .o_last (w_asm_last)
    );

    always_comb begin
        w_hdr_next = r_state;
        if (r_state == S_HDR_I) begin
            if (w_hval > 32'(IMEM_LINES_MAX))      w_hdr_next = S_ERROR;
            else if (w_hval == 32'd0)              w_hdr_next = S_HDR_D;
            else                                   w_hdr_next = S_IMEM;
        end else begin
            if (w_hval > 32'(DMEM_WORDS_MAX))      w_hdr_next = S_ERROR;
            else if (w_hval == 32'd0)              w_hdr_next = S_LAST;
            else                                   w_hdr_next = S_DMEM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_HDR_I;
            r_rdy      <= 1'b0;
            r_hcnt     <= '0;
            r_hdr      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_loaddata <= '0;
            r_loadaddr <= '0;
            r_imem_we  <= 1'b0;
            r_dmem_we  <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_rdy     <= 1'b1;
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;
            case (r_state)
                S_HDR_I, S_HDR_D: begin
                    if (w_acc) begin
                        r_hdr  <= w_hval[31:8];
                        r_hcnt <= r_hcnt + 2'd1;
                        r_cnt  <= w_hval[IW-1:0];
                        r_idx  <= '0;
                        if (r_hcnt == 2'(HDR_BYTES - 1))
                            r_state <= w_hdr_next;
                    end
                end
                S_IMEM, S_DMEM: begin
                    if (w_asm_last) begin
                        if (r_state == S_IMEM) begin
                            r_loaddata <= w_asm_next;
                            r_loadaddr <= ADDR_LEN'({r_idx, 4'b0000});
                            r_imem_we  <= 1'b1;
                        end else begin
                            r_loaddata <= {w_asm_next[INSN_LEN-1:0], {(DATA_LEN-INSN_LEN){1'b0}}};
                            r_loadaddr <= ADDR_LEN'({r_idx, 2'b00});
                            r_dmem_we  <= 1'b1;
                        end
                    end
                    if (r_imem_we | r_dmem_we) begin
                        r_idx <= r_idx + IW'(1);
                        if (w_sec_end)
                            r_state <= (r_state == S_IMEM) ? S_HDR_D : S_LAST;
                    end
                end
`ifdef PROG_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (w_acc)
                        r_state <= (rx_data == r_sum) ? S_DONE : S_ERROR;
                end
`endif
                default: ;
            endcase
`ifdef PROG_LOADER_CHKSUM_EN
            if (w_acc & w_payload)
                r_sum <= r_sum + rx_data;
`endif
        end
    end

    assign prog_loaddata = r_loaddata;
    assign prog_loadaddr = r_loadaddr;
    assign prog_imem_we  = r_imem_we;
    assign prog_dmem_we  = r_dmem_we;
    assign loaded        = (r_state == S_DONE);
    assign load_err      = (r_state == S_ERROR);
    assign prog_loading  = (r_state != S_DONE);
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; checksum scenarios build only with PROG_LOADER_CHKSUM_EN.
module tb_prog_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [127:0] prog_loaddata;
    logic [31:0]  prog_loadaddr;
    logic         prog_imem_we, prog_dmem_we, prog_loading, loaded, load_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  ia[$];
    logic [127:0] id[$];
    logic [31:0]  da[$];
    logic [127:0] dd[$];

    localparam logic [127:0] LINE0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] LINE1 = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] LINE2 = 128'h202122232425262728292a2b2c2d2e2f;

    prog_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prog_loaddata(prog_loaddata), .prog_loadaddr(prog_loadaddr),
        .prog_imem_we(prog_imem_we), .prog_dmem_we(prog_dmem_we),
        .prog_loading(prog_loading), .loaded(loaded), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_imem_we) begin ia.push_back(prog_loadaddr); id.push_back(prog_loaddata); end
        if (prog_dmem_we) begin da.push_back(prog_loadaddr); dd.push_back(prog_loaddata); end
    end

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ia.delete(); id.delete(); da.delete(); dd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && t < 100) begin @(negedge clk); t++; end
        if (!rx_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_byte: rx_ready stuck low, byte %h not accepted", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_image0();
        send_word(32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_word(32'd0);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!loaded && !load_err && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b exp 0", rx_ready); end
        n_tests++; if (prog_loaddata !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", prog_loaddata); end
        n_tests++; if (prog_loadaddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h exp 0", prog_loadaddr); end
        n_tests++; if ({prog_imem_we, prog_dmem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b exp 00", {prog_imem_we, prog_dmem_we}); end
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got %b exp 100", {prog_loading, loaded, load_err}); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_first_cycle: got %b exp 0", rx_ready); end
        @(negedge clk);
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_second_cycle: got %b exp 1", rx_ready); end
    endtask

    task automatic test_imem_single();
        do_reset();
        send_image0();
`ifdef PROG_LOADER_CHKSUM_EN
        send_byte(8'h78);
`endif
        wait_end();
        n_tests++; if (ia.size() != 1 || da.size() != 0) begin n_fail++; $display("FAIL t1_count: got imem=%0d dmem=%0d exp 1/0", ia.size(), da.size()); end
        n_tests++; if (ia.size() < 1 || ia[0] !== 32'h0) begin n_fail++; $display("FAIL t1_addr: got %h exp 0", ia.size() ? ia[0] : 32'hx); end
        n_tests++; if (id.size() < 1 || id[0] !== LINE0) begin n_fail++; $display("FAIL t1_data: got %h exp %h", id.size() ? id[0] : 128'hx, LINE0); end
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b010) begin n_fail++; $display("FAIL t1_status: got %b exp 010", {prog_loading, loaded, load_err}); end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL t1_done_rdy: got %b exp 0", rx_ready); end
    endtask

    task automatic test_dmem();
        do_reset();
        send_word(32'd0);
        send_word(32'd2);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef PROG_LOADER_CHKSUM_EN
        send_byte(8'h42);
`endif
        wait_end();
        n_tests++; if (da.size() != 2 || ia.size() != 0) begin n_fail++; $display("FAIL t2_count: got dmem=%0d imem=%0d exp 2/0", da.size(), ia.size()); end
        n_tests++; if (da.size() < 2 || da[0] !== 32'h0 || da[1] !== 32'h4) begin n_fail++; $display("FAIL t2_addr: got %h %h exp 0 4", da.size() > 0 ? da[0] : 32'hx, da.size() > 1 ? da[1] : 32'hx); end
        n_tests++; if (dd.size() < 1 || dd[0] !== {32'hDEADBEEF, 96'h0}) begin n_fail++; $display("FAIL t2_word0: got %h exp deadbeef", dd.size() ? dd[0] : 128'hx); end
        n_tests++; if (dd.size() < 2 || dd[1] !== {32'h01020304, 96'h0}) begin n_fail++; $display("FAIL t2_word1: got %h exp 01020304", dd.size() > 1 ? dd[1] : 128'hx); end
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b010) begin n_fail++; $display("FAIL t2_status: got %b exp 010", {prog_loading, loaded, load_err}); end
    endtask

    task automatic test_oversize();
        do_reset();
        send_word(32'd513);
        @(negedge clk);
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b101) begin n_fail++; $display("FAIL t3_status: got %b exp 101", {prog_loading, loaded, load_err}); end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL t3_rdy: got %b exp 0", rx_ready); end
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (ia.size() + da.size() != 0) begin n_fail++; $display("FAIL t3_no_write: got %0d writes exp 0", ia.size() + da.size()); end
        n_tests++; if (load_err !== 1'b1 || loaded !== 1'b0) begin n_fail++; $display("FAIL t3_sticky: got err=%b loaded=%b exp 1/0", load_err, loaded); end
    endtask

    task automatic test_valid_toggle();
        do_reset();
        send_word(32'd2);
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
                @(posedge clk); #1;
            end
            send_byte(8'h10 + 8'(i));
        end
        send_word(32'd0);
`ifdef PROG_LOADER_CHKSUM_EN
        send_byte(8'hF0);
`endif
        wait_end();
        n_tests++; if (ia.size() != 2) begin n_fail++; $display("FAIL t4_count: got %0d exp 2", ia.size()); end
        n_tests++; if (ia.size() < 2 || ia[0] !== 32'h00 || ia[1] !== 32'h10) begin n_fail++; $display("FAIL t4_addr: got %h %h exp 0 10", ia.size() > 0 ? ia[0] : 32'hx, ia.size() > 1 ? ia[1] : 32'hx); end
        n_tests++; if (id.size() < 1 || id[0] !== LINE1) begin n_fail++; $display("FAIL t4_line0: got %h exp %h", id.size() ? id[0] : 128'hx, LINE1); end
        n_tests++; if (id.size() < 2 || id[1] !== LINE2) begin n_fail++; $display("FAIL t4_line1: got %h exp %h", id.size() > 1 ? id[1] : 128'hx, LINE2); end
        n_tests++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL t4_loaded: got %b exp 1", loaded); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_word(32'd1);
        for (int i = 0; i < 7; i++) send_byte(8'hAA);
        do_reset();
        send_image0();
`ifdef PROG_LOADER_CHKSUM_EN
        send_byte(8'h78);
`endif
        wait_end();
        n_tests++; if (ia.size() != 1) begin n_fail++; $display("FAIL t5_count: got %0d exp 1", ia.size()); end
        n_tests++; if (id.size() < 1 || id[0] !== LINE0 || ia[0] !== 32'h0) begin n_fail++; $display("FAIL t5_line: got %h exp %h", id.size() ? id[0] : 128'hx, LINE0); end
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b010) begin n_fail++; $display("FAIL t5_status: got %b exp 010", {prog_loading, loaded, load_err}); end
    endtask

`ifdef PROG_LOADER_CHKSUM_EN
    task automatic test_chksum_bad();
        do_reset();
        send_image0();
        send_byte(8'h78 ^ 8'h01);
        wait_end();
        n_tests++; if ({prog_loading, loaded, load_err} !== 3'b101) begin n_fail++; $display("FAIL t6_status: got %b exp 101", {prog_loading, loaded, load_err}); end
    endtask
`endif

    initial begin
        test_reset();
        test_imem_single();
        test_dmem();
        test_oversize();
        test_valid_toggle();
        test_reset_midload();
`ifdef PROG_LOADER_CHKSUM_EN
        test_chksum_bad();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
